ring_packetizer: RTL and testbench

//  Network-interface injector directly upstream of router 0 of the 4-node ring.

---
 rtl/ring_packetizer.sv | 110 +++++++++++
 tb/tb_ring_packetizer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_packetizer.sv
// Ring network-interface injector: turns (dest, len) commands plus payload words
// into head/body/tail wormhole flits behind a single registered output stage.
module ring_packetizer #(
  parameter logic [3:0]  SRC_ID = 4'd0,
  parameter int unsigned LEN_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_dest,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      pld_data,
  input  logic             pld_valid,
  output logic             pld_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_head,
  output logic             out_tail,
  output logic             busy
);

  localparam int unsigned FLIT_W = 32;
  localparam int unsigned SEQ_W  = 16;

  typedef enum logic {IDLE, BODY} state_t;

  typedef struct packed {
    logic [3:0]       dest;
    logic [3:0]       src;
    logic [7:0]       len;
    logic [SEQ_W-1:0] seq;
  } head_flit_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [SEQ_W-1:0]  seq, seq_nxt;
  logic [FLIT_W-1:0] data_nxt;
  logic              valid_nxt, head_nxt, tail_nxt;
  logic              can_load;
  head_flit_t        head_flit;

  // Output register is free, or its current flit leaves this cycle.
  assign can_load = !out_valid || out_ready;
  assign busy     = (state == BODY);

  assign head_flit = '{dest: cmd_dest, src: SRC_ID, len: 8'(cmd_len), seq: seq};

  // Next-state, handshake and output-register load decisions.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    seq_nxt       = seq;
    data_nxt      = out_data;
    head_nxt      = out_head;
    tail_nxt      = out_tail;
    valid_nxt     = out_valid && !out_ready;
    cmd_ready     = 1'b0;
    pld_ready     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = can_load;
        if (cmd_valid && can_load) begin
          data_nxt      = FLIT_W'(head_flit);
          head_nxt      = 1'b1;
          tail_nxt      = (cmd_len == '0);
          valid_nxt     = 1'b1;
          seq_nxt       = seq + SEQ_W'(1);
          remaining_nxt = cmd_len;
          state_nxt     = (cmd_len == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        pld_ready = can_load;
        if (pld_valid && can_load) begin
          data_nxt      = pld_data;
          head_nxt      = 1'b0;
          tail_nxt      = (remaining == LEN_W'(1));
          valid_nxt     = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, sequence counter and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      seq       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      seq       <= seq_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_head  <= head_nxt;
      out_tail  <= tail_nxt;
    end
  end

endmodule

// File: tb/tb_ring_packetizer.sv
// Directed vector bench for ring_packetizer: table of per-cycle stimulus and
// expected outputs, plus sequences for reset, seq wrap and mid-packet reset.
module tb_ring_packetizer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dest;
  logic [7:0]  cmd_len;
  logic [31:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_head;
  logic        out_tail;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ring_packetizer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_head(out_head), .out_tail(out_tail), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [3:0]  dest;
    logic [7:0]  len;
    logic        pv;
    logic [31:0] pd;
    logic        ordy;
    logic        e_crdy;
    logic        e_prdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_head;
    logic        e_tail;
    logic        e_busy;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t v(input logic cv, input logic [3:0] dest, input logic [7:0] len,
                             input logic pv, input logic [31:0] pd, input logic ordy,
                             input logic e_crdy, input logic e_prdy, input logic e_valid,
                             input logic [31:0] e_data, input logic e_head, input logic e_tail,
                             input logic e_busy);
    vec_t r;
    r.cv = cv; r.dest = dest; r.len = len; r.pv = pv; r.pd = pd; r.ordy = ordy;
    r.e_crdy = e_crdy; r.e_prdy = e_prdy; r.e_valid = e_valid; r.e_data = e_data;
    r.e_head = e_head; r.e_tail = e_tail; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_dest = 4'h0; cmd_len = 8'h00;
    pld_valid = 1'b0; pld_data = 32'h0; out_ready = 1'b1;
  endtask

  initial begin
    int bad_seq;

    // Test 2: dest=3 len=2; test 3: header-only; test 4: len=4 under toggling out_ready.
    vecs[0]  = v(1, 4'h3, 8'd2, 0, 32'h0,         1, 1, 0, 1, 32'h3002_0000, 1, 0, 1);
    vecs[1]  = v(0, 4'h0, 8'd0, 1, 32'hA5A5_0001, 1, 0, 1, 1, 32'hA5A5_0001, 0, 0, 1);
    vecs[2]  = v(0, 4'h0, 8'd0, 1, 32'hA5A5_0002, 1, 0, 1, 1, 32'hA5A5_0002, 0, 1, 0);
    vecs[3]  = v(1, 4'h2, 8'd0, 0, 32'h0,         1, 1, 0, 1, 32'h2000_0001, 1, 1, 0);
    vecs[4]  = v(0, 4'h0, 8'd0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         0, 0, 0);
    vecs[5]  = v(1, 4'h1, 8'd4, 0, 32'h0,         1, 1, 0, 1, 32'h1004_0002, 1, 0, 1);
    vecs[6]  = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0001, 0, 0, 0, 1, 32'h1004_0002, 1, 0, 1);
    vecs[7]  = v(1, 4'hF, 8'd3, 1, 32'hC0DE_0001, 0, 0, 0, 1, 32'h1004_0002, 1, 0, 1);
    vecs[8]  = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0001, 1, 0, 1, 1, 32'hC0DE_0001, 0, 0, 1);
    vecs[9]  = v(1, 4'hF, 8'd3, 1, 32'hC0DE_0002, 1, 0, 1, 1, 32'hC0DE_0002, 0, 0, 1);
    vecs[10] = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0003, 0, 0, 0, 1, 32'hC0DE_0002, 0, 0, 1);
    vecs[11] = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0003, 0, 0, 0, 1, 32'hC0DE_0002, 0, 0, 1);
    vecs[12] = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0003, 1, 0, 1, 1, 32'hC0DE_0003, 0, 0, 1);
    vecs[13] = v(0, 4'h0, 8'd0, 1, 32'hC0DE_0004, 1, 0, 1, 1, 32'hC0DE_0004, 0, 1, 0);
    vecs[14] = v(0, 4'h0, 8'd0, 0, 32'h0,         0, 0, 0, 1, 32'hC0DE_0004, 0, 1, 0);
    vecs[15] = v(0, 4'h0, 8'd0, 0, 32'h0,         0, 0, 0, 1, 32'hC0DE_0004, 0, 1, 0);
    vecs[16] = v(0, 4'h0, 8'd0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0, 32'h0,         0, 0, 0);

    // Test 1: reset held low for 3 cycles with random inputs.
    reset = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_dest  = 4'($urandom());
      cmd_len   = 8'($urandom());
      pld_valid = 1'($urandom_range(0, 1));
      pld_data  = $urandom();
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rst_valid", c, 32'(out_valid), 32'h0);
      chk("rst_data",  c, out_data,       32'h0);
      chk("rst_head",  c, 32'(out_head),  32'h0);
      chk("rst_tail",  c, 32'(out_tail),  32'h0);
      chk("rst_busy",  c, 32'(busy),      32'h0);
      chk("rst_crdy",  c, 32'(cmd_ready), 32'h1);
      chk("rst_prdy",  c, 32'(pld_ready), 32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cmd_valid = vecs[i].cv; cmd_dest = vecs[i].dest; cmd_len = vecs[i].len;
      pld_valid = vecs[i].pv; pld_data = vecs[i].pd;   out_ready = vecs[i].ordy;
      #1;
      chk("cmd_ready", i, 32'(cmd_ready), 32'(vecs[i].e_crdy));
      chk("pld_ready", i, 32'(pld_ready), 32'(vecs[i].e_prdy));
      tick();
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
      chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
      if (vecs[i].e_valid) begin
        chk("out_data", i, out_data,       vecs[i].e_data);
        chk("out_head", i, 32'(out_head),  32'(vecs[i].e_head));
        chk("out_tail", i, 32'(out_tail),  32'(vecs[i].e_tail));
      end
    end

    // Test 5: walk seq through 0000..FFFE with header-only packets, then FFFF and wrap.
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_dest = 4'h7; cmd_len = 8'd0;
    bad_seq = 0;
    for (int k = 0; k < 65535; k++) begin
      tick();
      if (out_data !== {4'h7, 4'h0, 8'h00, 16'(k)} || out_valid !== 1'b1 ||
          out_head !== 1'b1 || out_tail !== 1'b1 || busy !== 1'b0)
        bad_seq++;
    end
    chk("seq_walk_errs", 0, 32'(bad_seq), 32'h0);
    tick();
    chk("seq_ffff", 0, out_data, 32'h7000_FFFF);
    tick();
    chk("seq_wrap", 0, out_data, 32'h7000_0000);
    chk("seq_wrap_ht", 0, 32'({out_head, out_tail}), 32'h3);

    // Test 6: reset after the 2nd body flit of a len=5 packet, then a clean len=1 packet.
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_dest = 4'h4; cmd_len = 8'd5;
    tick();
    chk("p6_head", 0, out_data, 32'h4005_0000);
    cmd_valid = 1'b0; pld_valid = 1'b1; pld_data = 32'hBEEF_0001;
    tick();
    chk("p6_body", 1, out_data, 32'hBEEF_0001);
    pld_data = 32'hBEEF_0002;
    tick();
    chk("p6_body", 2, out_data, 32'hBEEF_0002);
    chk("p6_busy", 2, 32'(busy), 32'h1);
    reset = 1'b0; pld_data = 32'hBEEF_0003;
    tick();
    chk("p6_rst_valid", 0, 32'(out_valid), 32'h0);
    chk("p6_rst_busy",  0, 32'(busy),      32'h0);
    chk("p6_rst_crdy",  0, 32'(cmd_ready), 32'h1);
    reset = 1'b1; pld_valid = 1'b0;
    cmd_valid = 1'b1; cmd_dest = 4'h9; cmd_len = 8'd1;
    tick();
    chk("p6_new_head", 0, out_data, 32'h9001_0000);
    chk("p6_new_ht",   0, 32'({out_valid, out_head, out_tail}), 32'h6);
    cmd_valid = 1'b0; pld_valid = 1'b1; pld_data = 32'h1234_5678;
    #1;
    chk("p6_new_prdy", 0, 32'(pld_ready), 32'h1);
    tick();
    chk("p6_new_tail", 0, out_data, 32'h1234_5678);
    chk("p6_new_ht",   1, 32'({out_valid, out_head, out_tail}), 32'h5);
    chk("p6_new_busy", 0, 32'(busy), 32'h0);
    pld_valid = 1'b0;
    tick();
    chk("p6_drained", 0, 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
